// File: rtl/image_streamer.sv
// rtl/image_streamer.sv - raster-order image reader feeding the convolution line buffer.
// Optional INTER_ROW_GAP_EN inserts ROW_GAP idle cycles after every row except the last.
`timescale 1ns/1ps
module image_streamer #(
    parameter int input_width = 8,
    parameter int im_dim      = 28,
    parameter int addr_width  = 16,
    parameter int ROW_GAP     = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [addr_width-1:0]  base_addr_i,
    input  logic                   stall_i,
    output logic                   mem_req_o,
    output logic [addr_width-1:0]  mem_addr_o,
    input  logic [input_width-1:0] mem_rdata_i,
    output logic [input_width-1:0] pixel_o,
    output logic                   pix_data_valid_o,
    output logic                   row_end_o,
    output logic                   busy_o,
    output logic                   frame_done_o
);

    localparam int NPIX = im_dim * im_dim;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int CLW  = $clog2(im_dim + 1);
    localparam int GW   = $clog2(ROW_GAP + 2);

    localparam logic [CW-1:0]  NPIX_C    = CW'(NPIX);
    localparam logic [CW-1:0]  LAST_PIX  = CW'(NPIX - 1);
    localparam logic [CLW-1:0] LAST_IDX  = CLW'(im_dim - 1);
`ifdef INTER_ROW_GAP_EN
    localparam logic [GW-1:0]  GAP_LOAD  = GW'(ROW_GAP);
`else
    localparam logic [GW-1:0]  GAP_LOAD  = '0;
`endif

    typedef enum logic [2:0] {IDLE, PRIME, STREAM, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [addr_width-1:0]  base_q;
    logic [CW-1:0]          issued_q, emitted_q;
    logic [CLW-1:0]         col_q, row_q;
    logic [GW-1:0]          gap_q;
    logic                   rvalid_q;
    logic [input_width-1:0] skid_q [2];
    logic [1:0]             skid_cnt_q, skid_cnt_d;

    logic                   emit, pop, push, issue, last_col;
    logic [input_width-1:0] emit_data;

    // Two-entry skid: a registered request plus returning data can both be caught by one stall.
    always_comb begin
        emit       = ((skid_cnt_q != 2'd0) || rvalid_q) && !stall_i && (gap_q == '0);
        emit_data  = (skid_cnt_q != 2'd0) ? skid_q[0] : mem_rdata_i;
        pop        = emit && (skid_cnt_q != 2'd0);
        push       = rvalid_q && !(emit && (skid_cnt_q == 2'd0));
        skid_cnt_d = skid_cnt_q - 2'(pop) + 2'(push);
        last_col   = (col_q == LAST_IDX);
        issue      = (state_q == PRIME) ||
                     ((state_q == STREAM) && (issued_q < NPIX_C) &&
                      (({1'b0, skid_cnt_d} + {2'b00, mem_req_o}) < 3'd2));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = PRIME;
            PRIME:   state_d = (NPIX > 1) ? STREAM : DRAIN;
            STREAM:  if (issue && (issued_q == LAST_PIX)) state_d = DRAIN;
            DRAIN:   if (emitted_q == NPIX_C) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o       = (state_q == PRIME) || (state_q == STREAM) || (state_q == DRAIN);
    assign frame_done_o = (state_q == DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            base_q           <= '0;
            issued_q         <= '0;
            emitted_q        <= '0;
            col_q            <= '0;
            row_q            <= '0;
            gap_q            <= '0;
            rvalid_q         <= 1'b0;
            skid_q[0]        <= '0;
            skid_q[1]        <= '0;
            skid_cnt_q       <= 2'd0;
            mem_req_o        <= 1'b0;
            mem_addr_o       <= '0;
            pixel_o          <= '0;
            pix_data_valid_o <= 1'b0;
            row_end_o        <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && start_i) begin
                base_q    <= base_addr_i;
                issued_q  <= '0;
                emitted_q <= '0;
                col_q     <= '0;
                row_q     <= '0;
            end

            mem_req_o <= issue;
            if (issue) begin
                mem_addr_o <= base_q + addr_width'(issued_q);
                issued_q   <= issued_q + CW'(1);
            end
            rvalid_q <= mem_req_o;

            if (pop) skid_q[0] <= skid_q[1];
            if (push) begin
                if ((skid_cnt_q - 2'(pop)) == 2'd0) skid_q[0] <= mem_rdata_i;
                else                                skid_q[1] <= mem_rdata_i;
            end
            skid_cnt_q <= skid_cnt_d;

            pix_data_valid_o <= emit;
            row_end_o        <= emit && last_col;
            if (emit) begin
                pixel_o   <= emit_data;
                emitted_q <= emitted_q + CW'(1);
                col_q     <= last_col ? '0 : col_q + CLW'(1);
                if (last_col) row_q <= row_q + CLW'(1);
            end

            // The gap after the final row is skipped so DONE is not delayed.
            if (emit && last_col && (row_q != LAST_IDX)) gap_q <= GAP_LOAD;
            else if (gap_q != '0)                        gap_q <= gap_q - GW'(1);
        end
    end

endmodule

// File: tb/tb_image_streamer.sv
// tb/tb_image_streamer.sv - directed self-checking bench for image_streamer (28x28 and 4x4 instances).
`timescale 1ns/1ps
module tb_image_streamer;

`ifdef INTER_ROW_GAP_EN
    localparam int GAP28 = 27 * 2;
    localparam int GAP4  = 3 * 2;
`else
    localparam int GAP28 = 0;
    localparam int GAP4  = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni = 1'b0;
    logic        start_a = 1'b0, stall_a = 1'b0, start_b = 1'b0, stall_b = 1'b0;
    logic [15:0] base_a = '0, base_b = '0, addr_a, addr_b;
    logic [7:0]  rdata_a = '0, rdata_b = '0, pix_a, pix_b;
    logic        req_a, val_a, re_a, busy_a, done_a;
    logic        req_b, val_b, re_b, busy_b, done_b;

    image_streamer #(.input_width(8), .im_dim(28), .addr_width(16), .ROW_GAP(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_a), .base_addr_i(base_a), .stall_i(stall_a),
        .mem_req_o(req_a), .mem_addr_o(addr_a), .mem_rdata_i(rdata_a), .pixel_o(pix_a),
        .pix_data_valid_o(val_a), .row_end_o(re_a), .busy_o(busy_a), .frame_done_o(done_a));

    image_streamer #(.input_width(8), .im_dim(4), .addr_width(16), .ROW_GAP(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_b), .base_addr_i(base_b), .stall_i(stall_b),
        .mem_req_o(req_b), .mem_addr_o(addr_b), .mem_rdata_i(rdata_b), .pixel_o(pix_b),
        .pix_data_valid_o(val_b), .row_end_o(re_b), .busy_o(busy_b), .frame_done_o(done_b));

    // Image memory content: mem[a] = a[7:0], one-cycle read latency.
    always @(posedge clk) begin
        if (req_a) rdata_a <= addr_a[7:0];
        if (req_b) rdata_b <= addr_b[7:0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame monitors: order/value/row_end errors are accumulated and checked per frame.
    bit          a_clr = 1'b0, b_clr = 1'b0;
    logic [15:0] a_base = '0, b_base = '0, a_addr0 = '0;
    logic [15:0] b_addrs [3];
    int a_cnt = 0, a_seq = 0, a_re = 0, a_first = 0, a_last = 0, a_dn = 0, a_dcyc = 0, a_req = 0;
    int b_cnt = 0, b_seq = 0, b_re = 0, b_dn = 0, b_dcyc = 0, b_req = 0;

    always @(negedge clk) begin
        if (a_clr) begin
            a_cnt = 0; a_seq = 0; a_re = 0; a_first = 0; a_last = 0; a_dn = 0; a_dcyc = 0; a_req = 0;
        end else begin
            if (val_a) begin
                if (pix_a !== 8'(a_base + 16'(a_cnt))) a_seq++;
                if (re_a !== ((a_cnt % 28) == 27)) a_re++;
                if (a_cnt == 0) a_first = cyc;
                a_last = cyc;
                a_cnt++;
            end else if (re_a) a_re++;
            if (done_a) begin a_dn++; a_dcyc = cyc; end
            if (req_a && a_req == 0) a_addr0 = addr_a;
            if (req_a) a_req++;
        end
    end

    always @(negedge clk) begin
        if (b_clr) begin
            b_cnt = 0; b_seq = 0; b_re = 0; b_dn = 0; b_dcyc = 0; b_req = 0;
        end else begin
            if (val_b) begin
                if (pix_b !== 8'(b_base + 16'(b_cnt))) b_seq++;
                if (re_b !== ((b_cnt % 4) == 3)) b_re++;
                b_cnt++;
            end else if (re_b) b_re++;
            if (done_b) begin b_dn++; b_dcyc = cyc; end
            if (req_b && b_req < 3) b_addrs[b_req] = addr_b;
            if (req_b) b_req++;
        end
    end

    task automatic start_frame_a(input logic [15:0] b, output int s);
        @(negedge clk); #1;
        base_a = b; a_base = b; a_clr = 1'b1;
        @(negedge clk); #1;
        a_clr = 1'b0; start_a = 1'b1;
        @(negedge clk);
        s = cyc;
        #1 start_a = 1'b0;
    endtask

    task automatic wait_a_cnt(input int n);
        for (int i = 0; i < 3000 && a_cnt < n; i++) begin
            @(negedge clk); #1;
        end
        if (a_cnt < n) check_eq("timeout_pix", 32'(a_cnt), 32'(n));
    endtask

    task automatic wait_a_done();
        for (int i = 0; i < 3000 && a_dn == 0; i++) begin
            @(negedge clk); #1;
        end
        if (a_dn == 0) check_eq("timeout_done", 32'(a_dn), 32'd1);
    endtask

    int s;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_a", 32'({val_a, re_a, busy_a, done_a, req_a, pix_a, addr_a}), 32'd0);
        check_eq("reset_b", 32'({val_b, re_b, busy_b, done_b, req_b, pix_b, addr_b}), 32'd0);
        rst_ni = 1'b1;

        // Basic frame with a start pulse in the middle that must be ignored.
        start_frame_a(16'h0000, s);
        wait_a_cnt(300);
        base_a = 16'h0050; start_a = 1'b1;
        @(negedge clk); #1;
        start_a = 1'b0; base_a = 16'h0000;
        wait_a_done();
        repeat (10) @(negedge clk);
        #1;
        check_eq("a_count", 32'(a_cnt), 32'd784);
        check_eq("a_values", 32'(a_seq), 32'd0);
        check_eq("a_row_end", 32'(a_re), 32'd0);
        check_eq("a_first_lat", 32'(a_first - s), 32'd3);
        check_eq("a_last_lat", 32'(a_last - s), 32'(786 + GAP28));
        check_eq("a_done_lat", 32'(a_dcyc - s), 32'(787 + GAP28));
        check_eq("a_done_once", 32'(a_dn), 32'd1);
        check_eq("a_idle", 32'({busy_a, val_a}), 32'd0);

        // New base from IDLE, stall 5 cycles at pixel 100 and 1 cycle at the last pixel.
        start_frame_a(16'h0100, s);
        wait_a_cnt(100);
        stall_a = 1'b1;
        repeat (5) @(negedge clk);
        #1 stall_a = 1'b0;
        wait_a_cnt(783);
        stall_a = 1'b1;
        @(negedge clk);
        #1 stall_a = 1'b0;
        wait_a_done();
        repeat (5) @(negedge clk);
        #1;
        check_eq("b0100_addr0", 32'(a_addr0), 32'h0100);
        check_eq("stall_count", 32'(a_cnt), 32'd784);
        check_eq("stall_values", 32'(a_seq), 32'd0);
        check_eq("stall_done_lat", 32'(a_dcyc - s), 32'(787 + GAP28 + 6));

        // Asynchronous reset mid-frame, then a clean full frame.
        start_frame_a(16'h0000, s);
        wait_a_cnt(400);
        rst_ni = 1'b0;
        #1;
        check_eq("rst_mid_a", 32'({val_a, re_a, busy_a, done_a, req_a, pix_a, addr_a}), 32'd0);
        @(negedge clk); #1;
        rst_ni = 1'b1;
        start_frame_a(16'h0000, s);
        wait_a_done();
        repeat (5) @(negedge clk);
        #1;
        check_eq("rst_count", 32'(a_cnt), 32'd784);
        check_eq("rst_values", 32'(a_seq), 32'd0);
        check_eq("rst_row_end", 32'(a_re), 32'd0);
        check_eq("rst_first_lat", 32'(a_first - s), 32'd3);
        check_eq("rst_done_lat", 32'(a_dcyc - s), 32'(787 + GAP28));

        // 4x4 image with address wrap past 0xFFFF.
        @(negedge clk); #1;
        base_b = 16'hFFFE; b_base = 16'hFFFE; b_clr = 1'b1;
        @(negedge clk); #1;
        b_clr = 1'b0; start_b = 1'b1;
        @(negedge clk);
        s = cyc;
        #1 start_b = 1'b0;
        for (int i = 0; i < 200 && b_dn == 0; i++) begin
            @(negedge clk); #1;
        end
        if (b_dn == 0) check_eq("timeout_b", 32'(b_dn), 32'd1);
        repeat (5) @(negedge clk);
        #1;
        check_eq("wrap_addr0", 32'(b_addrs[0]), 32'hFFFE);
        check_eq("wrap_addr1", 32'(b_addrs[1]), 32'hFFFF);
        check_eq("wrap_addr2", 32'(b_addrs[2]), 32'h0000);
        check_eq("small_count", 32'(b_cnt), 32'd16);
        check_eq("small_values", 32'(b_seq), 32'd0);
        check_eq("small_row_end", 32'(b_re), 32'd0);
        check_eq("small_done_lat", 32'(b_dcyc - s), 32'(19 + GAP4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
